// File: rtl/rename_regfile_pkg.sv
// rename_regfile_pkg: shared Tomasulo types for the renaming register file.
// Defaults: RF_WIDTH/RF_NUM_REGS/RF_TAG_W/RF_NUM_DISP/RF_NUM_CDB.
// Entry and read-result structs are sized to the supported maxima so the
// parameterised modules can carry any WIDTH <= RF_MAX_W, TAG_W <= RF_MAX_TAG_W.
package rename_regfile_pkg;

    localparam int RF_WIDTH     = 32;
    localparam int RF_NUM_REGS  = 32;
    localparam int RF_TAG_W     = 4;
    localparam int RF_NUM_DISP  = 2;
    localparam int RF_NUM_CDB   = 2;
    localparam int RF_MAX_W     = 64;
    localparam int RF_MAX_TAG_W = 16;

    typedef struct packed {
        logic [RF_MAX_W-1:0]     data;
        logic [RF_MAX_TAG_W-1:0] tag;
        logic                    busy;
    } rf_entry_t;

    typedef struct packed {
        logic                busy;
        logic [RF_MAX_W-1:0] val;
    } rf_rd_t;

endpackage

// File: rtl/rename_regfile_src_fwd.sv
// regfile_src_fwd: resolves one source operand of one dispatch slot.
// Ports: idx_i source index; ent_* stored entry for idx_i; alloc_* same-cycle
// renames of all slots (only slots below SLOT are visible); cdb_* same-cycle
// broadcasts (used only when REGFILE_CDB_BYPASS_EN is defined);
// busy_o/val_o resolved operand (tag zero-extended while busy).
module regfile_src_fwd
    import rename_regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int TAG_W    = RF_TAG_W,
    parameter int IW       = 5,
    parameter int NUM_DISP = RF_NUM_DISP,
    parameter int NUM_CDB  = RF_NUM_CDB,
    parameter int SLOT     = 0
) (
    input  logic [IW-1:0]                     idx_i,
    input  logic                              ent_busy_i,
    input  logic [TAG_W-1:0]                  ent_tag_i,
    input  logic [WIDTH-1:0]                  ent_data_i,
    input  logic [NUM_DISP-1:0]               alloc_valid_i,
    input  logic [NUM_DISP-1:0][IW-1:0]       alloc_rd_i,
    input  logic [NUM_DISP-1:0][TAG_W-1:0]    alloc_tag_i,
    input  logic [NUM_CDB-1:0]                cdb_valid_i,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]     cdb_tag_i,
    input  logic [NUM_CDB-1:0][WIDTH-1:0]     cdb_data_i,
    output logic                              busy_o,
    output logic [WIDTH-1:0]                  val_o
);

    rf_rd_t res;
    logic   unused_sink;

    always_comb begin
        res.busy = ent_busy_i;
        res.val  = ent_busy_i ? RF_MAX_W'(ent_tag_i) : RF_MAX_W'(ent_data_i);
`ifdef REGFILE_CDB_BYPASS_EN
        // descending scan so the lowest matching bus is applied last and wins
        for (int n = NUM_CDB - 1; n >= 0; n--)
            if (ent_busy_i && cdb_valid_i[n] && cdb_tag_i[n] == ent_tag_i) begin
                res.busy = 1'b0;
                res.val  = RF_MAX_W'(cdb_data_i[n]);
            end
`endif
        // older slots of the same group override both stored state and bypass
        for (int e = 0; e < SLOT; e++)
            if (alloc_valid_i[e] && alloc_rd_i[e] == idx_i) begin
                res.busy = 1'b1;
                res.val  = RF_MAX_W'(alloc_tag_i[e]);
            end
        if (idx_i == '0)
            res = '0;
    end

    assign busy_o      = res.busy;
    assign val_o       = res.val[WIDTH-1:0];
    assign unused_sink = ^{res, alloc_valid_i, alloc_rd_i, alloc_tag_i, cdb_valid_i, cdb_tag_i, cdb_data_i};

endmodule

// File: rtl/rename_regfile.sv
// rename_regfile: Tomasulo register file with rename tags and CDB writeback.
// Ports: clk, rst_n (async active-low); cdb_valid/cdb_tag/cdb_data result
// broadcasts; alloc_valid/alloc_rd/alloc_tag per-slot renames; rs1_idx/rs2_idx
// source indices with rs1_busy/rs1_val, rs2_busy/rs2_val combinational reads;
// flush clears all pending state; busy_count registered count of busy entries.
// Optional: REGFILE_CDB_BYPASS_EN forwards same-cycle broadcasts to reads.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int TAG_W    = RF_TAG_W,
    parameter int NUM_DISP = RF_NUM_DISP,
    parameter int NUM_CDB  = RF_NUM_CDB,
    localparam int IW      = $clog2(NUM_REGS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CDB-1:0]                cdb_valid,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]     cdb_tag,
    input  logic [NUM_CDB-1:0][WIDTH-1:0]     cdb_data,
    input  logic [NUM_DISP-1:0]               alloc_valid,
    input  logic [NUM_DISP-1:0][IW-1:0]       alloc_rd,
    input  logic [NUM_DISP-1:0][TAG_W-1:0]    alloc_tag,
    input  logic [NUM_DISP-1:0][IW-1:0]       rs1_idx,
    input  logic [NUM_DISP-1:0][IW-1:0]       rs2_idx,
    output logic [NUM_DISP-1:0]               rs1_busy,
    output logic [NUM_DISP-1:0][WIDTH-1:0]    rs1_val,
    output logic [NUM_DISP-1:0]               rs2_busy,
    output logic [NUM_DISP-1:0][WIDTH-1:0]    rs2_val,
    input  logic                              flush,
    output logic [IW:0]                       busy_count
);

    rf_entry_t   ent_q [NUM_REGS];
    rf_entry_t   ent_d [NUM_REGS];
    logic [IW:0] busy_count_q, busy_count_d;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            ent_d[r] = ent_q[r];
        // entry 0 is never written, so it stays at its reset value of zero
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int n = NUM_CDB - 1; n >= 0; n--)
                if (cdb_valid[n] && ent_q[r].busy && ent_q[r].tag == RF_MAX_TAG_W'(cdb_tag[n])) begin
                    ent_d[r].data = RF_MAX_W'(cdb_data[n]);
                    ent_d[r].busy = 1'b0;
                end
            // ascending scan: youngest slot lands last; allocation beats writeback
            for (int d = 0; d < NUM_DISP; d++)
                if (alloc_valid[d] && alloc_rd[d] == IW'(r)) begin
                    ent_d[r].busy = 1'b1;
                    ent_d[r].tag  = RF_MAX_TAG_W'(alloc_tag[d]);
                end
            if (flush)
                ent_d[r].busy = 1'b0;
        end
        busy_count_d = '0;
        for (int r = 0; r < NUM_REGS; r++)
            busy_count_d = busy_count_d + {{IW{1'b0}}, ent_d[r].busy};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                ent_q[r] <= '0;
            busy_count_q <= '0;
        end else begin
            ent_q        <= ent_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    for (genvar d = 0; d < NUM_DISP; d++) begin : g_slot
        regfile_src_fwd #(
            .WIDTH(WIDTH), .TAG_W(TAG_W), .IW(IW),
            .NUM_DISP(NUM_DISP), .NUM_CDB(NUM_CDB), .SLOT(d)
        ) u_rs1 (
            .idx_i        (rs1_idx[d]),
            .ent_busy_i   (ent_q[rs1_idx[d]].busy),
            .ent_tag_i    (ent_q[rs1_idx[d]].tag[TAG_W-1:0]),
            .ent_data_i   (ent_q[rs1_idx[d]].data[WIDTH-1:0]),
            .alloc_valid_i(alloc_valid),
            .alloc_rd_i   (alloc_rd),
            .alloc_tag_i  (alloc_tag),
            .cdb_valid_i  (cdb_valid),
            .cdb_tag_i    (cdb_tag),
            .cdb_data_i   (cdb_data),
            .busy_o       (rs1_busy[d]),
            .val_o        (rs1_val[d])
        );
        regfile_src_fwd #(
            .WIDTH(WIDTH), .TAG_W(TAG_W), .IW(IW),
            .NUM_DISP(NUM_DISP), .NUM_CDB(NUM_CDB), .SLOT(d)
        ) u_rs2 (
            .idx_i        (rs2_idx[d]),
            .ent_busy_i   (ent_q[rs2_idx[d]].busy),
            .ent_tag_i    (ent_q[rs2_idx[d]].tag[TAG_W-1:0]),
            .ent_data_i   (ent_q[rs2_idx[d]].data[WIDTH-1:0]),
            .alloc_valid_i(alloc_valid),
            .alloc_rd_i   (alloc_rd),
            .alloc_tag_i  (alloc_tag),
            .cdb_valid_i  (cdb_valid),
            .cdb_tag_i    (cdb_tag),
            .cdb_data_i   (cdb_data),
            .busy_o       (rs2_busy[d]),
            .val_o        (rs2_val[d])
        );
    end

endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: scoreboard bench for rename_regfile with directed vectors.
module tb_rename_regfile;

`ifdef REGFILE_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_RS1 = 0, K_RS2 = 1, K_CNT = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        cdb_valid;
    logic [1:0][3:0]   cdb_tag;
    logic [1:0][31:0]  cdb_data;
    logic [1:0]        alloc_valid;
    logic [1:0][4:0]   alloc_rd;
    logic [1:0][3:0]   alloc_tag;
    logic [1:0][4:0]   rs1_idx, rs2_idx;
    logic [1:0]        rs1_busy, rs2_busy;
    logic [1:0][31:0]  rs1_val, rs2_val;
    logic              flush;
    logic [5:0]        busy_count;

    rename_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_busy(rs1_busy), .rs1_val(rs1_val),
        .rs2_busy(rs2_busy), .rs2_val(rs2_val),
        .flush(flush), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        int          slot;
        logic        busy;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: pops every expectation due this cycle and compares mid-cycle
    always @(negedge clk) begin : mon
        exp_t        e;
        logic        ab;
        logic [31:0] av;
        logic        ok;
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not consumed until %0d", e.name, e.cyc, cyc);
            end else begin
                ab = e.kind == K_RS1 ? rs1_busy[e.slot] : rs2_busy[e.slot];
                av = e.kind == K_RS1 ? rs1_val[e.slot] : e.kind == K_RS2 ? rs2_val[e.slot] : {26'd0, busy_count};
                ok = e.kind == K_CNT ? (av === e.val) : (ab === e.busy && av === e.val);
                if (!ok) begin
                    errors++;
                    $display("FAIL %s: got busy=%b val=0x%08h, want busy=%b val=0x%08h", e.name, ab, av, e.busy, e.val);
                end
            end
        end
    end

    task automatic ex(input int k, input int s, input logic b, input logic [31:0] v, input string n);
        q.push_back('{cyc, k, s, b, v, n});
    endtask

    task automatic cnt(input int v, input string n);
        ex(K_CNT, 0, 1'b0, v, n);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        alloc_valid = '0; alloc_rd = '0; alloc_tag = '0;
        rs1_idx = '0; rs2_idx = '0; flush = 1'b0;
    endtask

    task automatic alloc(input int d, input int rd, input int tag);
        alloc_valid[d] = 1'b1; alloc_rd[d] = 5'(rd); alloc_tag[d] = 4'(tag);
    endtask

    task automatic cdb(input int n, input int tag, input logic [31:0] data);
        cdb_valid[n] = 1'b1; cdb_tag[n] = 4'(tag); cdb_data[n] = data;
    endtask

    initial begin
        step();
        step();
        rst_n = 1'b1;
        // reset state
        step(); rs1_idx[0] = 5; ex(K_RS1, 0, 0, 0, "rst_rd"); cnt(0, "rst_cnt");
        // alloc x5 tag 3, then broadcast DEADBEEF
        step(); alloc(0, 5, 3); rs1_idx[0] = 5; ex(K_RS1, 0, 0, 0, "own_alloc_hidden");
        step(); rs1_idx[0] = 5; ex(K_RS1, 0, 1, 3, "x5_pending"); cnt(1, "cnt_one");
        step(); cdb(0, 3, 32'hDEADBEEF); rs1_idx[0] = 5;
        ex(K_RS1, 0, !BYP, BYP ? 32'hDEADBEEF : 32'd3, "x5_cdb_same_cycle");
        step(); rs1_idx[0] = 5; ex(K_RS1, 0, 0, 32'hDEADBEEF, "x5_written"); cnt(0, "cnt_after_cdb");
        // re-rename x5: tag 3 then tag 7; old tag broadcast must not complete it
        step(); alloc(0, 5, 3);
        step(); alloc(0, 5, 7); cdb(0, 3, 32'h99); rs1_idx[0] = 5;
        ex(K_RS1, 0, !BYP, BYP ? 32'h99 : 32'd3, "x5_old_tag_same_cycle");
        step(); cdb(0, 3, 32'h77); rs1_idx[0] = 5; ex(K_RS1, 0, 1, 7, "x5_alloc_beats_cdb"); cnt(1, "cnt_retag");
        step(); cdb(0, 9, 32'h33); cdb(1, 7, 32'h11); rs1_idx[0] = 5;
        ex(K_RS1, 0, !BYP, BYP ? 32'h11 : 32'd7, "x5_new_tag_same_cycle");
        step(); rs1_idx[0] = 5; ex(K_RS1, 0, 0, 32'h11, "x5_new_tag_done"); cnt(0, "cnt_retag_done");
        // two buses with the same tag: bus 0 wins
        step(); alloc(1, 7, 6); rs2_idx[1] = 7; ex(K_RS2, 1, 0, 0, "own_alloc_hidden_s1");
        step(); cdb(0, 6, 32'hA0); cdb(1, 6, 32'hB0); rs2_idx[1] = 7;
        ex(K_RS2, 1, !BYP, BYP ? 32'hA0 : 32'd6, "dup_tag_same_cycle");
        step(); rs2_idx[1] = 7; ex(K_RS2, 1, 0, 32'hA0, "dup_tag_low_wins"); cnt(0, "cnt_dup");
        // intra-group forwarding
        step(); alloc(0, 2, 4); alloc(1, 2, 5); rs1_idx[1] = 2; rs2_idx[0] = 2;
        ex(K_RS1, 1, 1, 4, "intra_fwd"); ex(K_RS2, 0, 0, 0, "no_fwd_from_younger");
        step(); alloc(1, 9, 8); rs2_idx[0] = 9; rs2_idx[1] = 9; rs1_idx[0] = 2;
        ex(K_RS2, 0, 0, 0, "slot0_blind_to_slot1"); ex(K_RS2, 1, 0, 0, "own_alloc_hidden_x9");
        ex(K_RS1, 0, 1, 5, "youngest_alloc_wins"); cnt(1, "cnt_x2");
        step(); rs1_idx[0] = 9; ex(K_RS1, 0, 1, 8, "x9_pending"); cnt(2, "cnt_x2_x9");
        // x6 bypass and intra-group priority over bypass
        step(); alloc(0, 6, 2);
        step(); cdb(0, 2, 32'h55); alloc(0, 6, 10); rs1_idx[0] = 6; rs1_idx[1] = 6;
        ex(K_RS1, 0, !BYP, BYP ? 32'h55 : 32'd2, "x6_bypass");
        ex(K_RS1, 1, 1, 10, "intra_over_bypass"); cnt(3, "cnt_three");
        step(); rs1_idx[0] = 6; ex(K_RS1, 0, 1, 10, "x6_alloc_over_cdb");
        // x0 and flush
        step(); alloc(0, 0, 1); rs1_idx[1] = 0; rs2_idx[0] = 0;
        ex(K_RS1, 1, 0, 0, "x0_intra"); ex(K_RS2, 0, 0, 0, "x0_read"); cnt(3, "cnt_x0_ignored");
        step(); flush = 1'b1; alloc(0, 3, 11); cnt(3, "cnt_before_flush");
        step(); rs1_idx[0] = 2; rs2_idx[0] = 3; rs1_idx[1] = 5; rs2_idx[1] = 0;
        ex(K_RS1, 0, 0, 0, "flush_x2"); ex(K_RS2, 0, 0, 0, "flush_beats_alloc");
        ex(K_RS1, 1, 0, 32'h11, "flush_keeps_data"); ex(K_RS2, 1, 0, 0, "x0_after_flush");
        cnt(0, "cnt_after_flush");
        // asynchronous reset mid-run
        step(); alloc(0, 5, 3);
        step(); rs1_idx[0] = 5; ex(K_RS1, 0, 1, 3, "pre_rst_pending"); cnt(1, "pre_rst_cnt");
        step(); rst_n = 1'b0; alloc(0, 4, 9); rs1_idx[0] = 5; rs2_idx[1] = 7;
        ex(K_RS1, 0, 0, 0, "rst_async_x5"); ex(K_RS2, 1, 0, 0, "rst_async_x7"); cnt(0, "rst_async_cnt");
        step(); rst_n = 1'b1; alloc(0, 4, 1); rs1_idx[0] = 4; ex(K_RS1, 0, 0, 0, "post_rst_x4_clear");
        step(); rs1_idx[0] = 4; ex(K_RS1, 0, 1, 1, "post_rst_alloc"); cnt(1, "post_rst_cnt");
        step();
        step();
        step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
